// File: rtl/gate_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive gate sweep checker.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } sweep_state_e;

  // Sizing depends on module parameters, so these are functions rather than fixed constants.
  function automatic int unsigned nvec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned settle);
    return $clog2(settle) + 1;
  endfunction

  function automatic int unsigned err_w(input int unsigned n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Counts SETTLE cycles while enabled and flags the cycle in which the count reaches SETTLE-1.
module settle_timer
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = cnt_w(SETTLE);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = expire ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives every input vector onto a gate under test, samples its output after a settle interval
// and compares against a latched truth table, keeping a mismatch count and the first failure.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(1 << N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]          stim,
  input  logic                     dut_d,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_count,
  output logic [N_IN-1:0]          first_fail_idx,
  output logic                     first_fail_valid
);

  localparam int unsigned NVec = nvec(N_IN);
  localparam int unsigned ErrW = err_w(N_IN);

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [NVec-1:0] tt_q, tt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ErrW-1:0] err_q, err_d;
  logic [N_IN-1:0] ff_idx_q, ff_idx_d;
  logic            ff_valid_q, ff_valid_d;

  logic accept;
  logic expire;
  logic mismatch;

  assign accept   = (state_q == StIdle) && start;
  assign mismatch = expire && (dut_d != tt_q[stim_q]);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state_q == StRun),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    tt_d       = tt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    ff_idx_d   = ff_idx_q;
    ff_valid_d = ff_valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tt_d       = exp_tt;
          stim_d     = '0;
          err_d      = '0;
          ff_valid_d = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (expire) begin
          if (mismatch) begin
            err_d = err_q + ErrW'(1);
            if (!ff_valid_q) begin
              ff_idx_d   = stim_q;
              ff_valid_d = 1'b1;
            end
          end
          // Last vector: hold stim and report using the count that includes this sample.
          if (stim_q == '1) begin
            state_d = StFin;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            stim_d = stim_q + N_IN'(1);
          end
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      stim_q     <= '0;
      tt_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ff_idx_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      tt_q       <= tt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ff_idx_q   <= ff_idx_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a 2-input/SETTLE=2 instance and a 3-input/SETTLE=1 one.
module tb_gate_sweep_checker;

  logic clk;
  logic rst_n;

  // Instance A: N_IN=2, SETTLE=2
  logic       start_a;
  logic [3:0] exp_tt_a;
  logic [1:0] stim_a;
  logic       dut_d_a;
  logic       busy_a, done_a, pass_a, ffv_a;
  logic [2:0] err_a;
  logic [1:0] ffi_a;
  logic [1:0] mode_a;

  // Instance B: N_IN=3, SETTLE=1
  logic       start_b;
  logic [7:0] exp_tt_b;
  logic [2:0] stim_b;
  logic       dut_d_b;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [3:0] err_b;
  logic [2:0] ffi_b;

  int checks;
  int errors;

  // mode 0: AND gate, 1: OR gate, 2: output stuck at 0
  assign dut_d_a = (mode_a == 2'd0) ? (stim_a[0] & stim_a[1]) :
                   (mode_a == 2'd1) ? (stim_a[0] | stim_a[1]) : 1'b0;
  assign dut_d_b = ^stim_b;

  gate_sweep_checker #(
    .N_IN   (2),
    .SETTLE (2)
  ) u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_a),
    .exp_tt           (exp_tt_a),
    .stim             (stim_a),
    .dut_d            (dut_d_a),
    .busy             (busy_a),
    .done             (done_a),
    .pass             (pass_a),
    .err_count        (err_a),
    .first_fail_idx   (ffi_a),
    .first_fail_valid (ffv_a)
  );

  gate_sweep_checker #(
    .N_IN   (3),
    .SETTLE (1)
  ) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_b),
    .exp_tt           (exp_tt_b),
    .stim             (stim_b),
    .dut_d            (dut_d_b),
    .busy             (busy_b),
    .done             (done_b),
    .pass             (pass_b),
    .err_count        (err_b),
    .first_fail_idx   (ffi_b),
    .first_fail_valid (ffv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start on A for one cycle; returns at the falling edge after the accepting edge E0.
  task automatic kick_a(input logic [3:0] tt, input logic [1:0] mode);
    @(negedge clk);
    mode_a   = mode;
    exp_tt_a = tt;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
  endtask

  // Wait (bounded) for A's done pulse; returns at the falling edge where done is seen.
  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done_a, n);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    exp_tt_a = '0;
    exp_tt_b = '0;
    mode_a   = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, ffi_a, ffv_a} !== 11'd0) begin
      errors++;
      $display("FAIL reset_a: got %b required all zero",
               {stim_a, busy_a, done_a, pass_a, err_a, ffi_a, ffv_a});
    end
    checks++;
    if ({stim_b, busy_b, done_b, pass_b, err_b, ffi_b, ffv_b} !== 14'd0) begin
      errors++;
      $display("FAIL reset_b: got %b required all zero",
               {stim_b, busy_b, done_b, pass_b, err_b, ffi_b, ffv_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Steps through E0..E9 of a sweep on A checking stim/busy/done; optional restart pulse at E3.
  task automatic run_timed_a(input string name, input bit poke);
    logic [1:0] e_stim;
    kick_a(4'b1000, 2'd0);
    for (int k = 0; k <= 9; k++) begin
      e_stim = (k < 8) ? 2'(k / 2) : 2'd3;
      checks++;
      if (stim_a !== e_stim || busy_a !== (k <= 8) || done_a !== (k == 8)) begin
        errors++;
        $display("FAIL %s E%0d: stim=%0d busy=%b done=%b required stim=%0d busy=%b done=%b",
                 name, k, stim_a, busy_a, done_a, e_stim, (k <= 8), (k == 8));
      end
      if (poke && k == 2) begin
        start_a  = 1'b1;
        exp_tt_a = 4'b0000;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (pass_a !== 1'b1 || err_a !== 3'd0 || ffv_a !== 1'b0) begin
      errors++;
      $display("FAIL %s result: pass=%b err=%0d ffv=%b required pass=1 err=0 ffv=0",
               name, pass_a, err_a, ffv_a);
    end
  endtask

  task automatic test_and_pass();
    run_timed_a("and_pass", 1'b0);
  endtask

  task automatic test_or_mismatch();
    kick_a(4'b1000, 2'd1);
    wait_done_a("or_mismatch");
    checks++;
    if (err_a !== 3'd2 || ffi_a !== 2'd1 || ffv_a !== 1'b1 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL or_mismatch: err=%0d idx=%0d ffv=%b pass=%b required err=2 idx=1 ffv=1 pass=0",
               err_a, ffi_a, ffv_a, pass_a);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err_a !== 3'd2 || ffi_a !== 2'd1 || ffv_a !== 1'b1 || pass_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL persist: err=%0d idx=%0d ffv=%b pass=%b busy=%b required 2 1 1 0 0",
               err_a, ffi_a, ffv_a, pass_a, busy_a);
    end
  endtask

  task automatic test_xor_settle1();
    int nbusy;
    int ndone;
    @(negedge clk);
    exp_tt_b = 8'h96;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy_b === 1'b1) nbusy++;
      if (done_b === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (nbusy != 9 || ndone != 1) begin
      errors++;
      $display("FAIL xor_timing: busy cycles=%0d done pulses=%0d required 9 and 1", nbusy, ndone);
    end
    checks++;
    if (pass_b !== 1'b1 || err_b !== 4'd0 || ffv_b !== 1'b0 || stim_b !== 3'd7) begin
      errors++;
      $display("FAIL xor_result: pass=%b err=%0d ffv=%b stim=%0d required 1 0 0 7",
               pass_b, err_b, ffv_b, stim_b);
    end
  endtask

  task automatic test_all_fail();
    kick_a(4'b1111, 2'd2);
    wait_done_a("all_fail");
    checks++;
    if (err_a !== 3'd4 || ffi_a !== 2'd0 || ffv_a !== 1'b1 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL all_fail: err=%0d idx=%0d ffv=%b pass=%b required err=4 idx=0 ffv=1 pass=0",
               err_a, ffi_a, ffv_a, pass_a);
    end
  endtask

  task automatic test_back_to_back();
    run_timed_a("restart_ignored", 1'b1);
  endtask

  task automatic test_reset_abort();
    int ndone;
    kick_a(4'b1000, 2'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, ffi_a, ffv_a} !== 11'd0) begin
      errors++;
      $display("FAIL async_abort: got %b required all zero",
               {stim_a, busy_a, done_a, pass_a, err_a, ffi_a, ffv_a});
    end
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_quiet: done/busy seen %0d times after abort, required 0", ndone);
    end
    kick_a(4'b1000, 2'd1);
    wait_done_a("fresh_sweep");
    checks++;
    if (err_a !== 3'd2 || ffi_a !== 2'd1 || ffv_a !== 1'b1 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL fresh_sweep: err=%0d idx=%0d ffv=%b pass=%b required err=2 idx=1 ffv=1 pass=0",
               err_a, ffi_a, ffv_a, pass_a);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_and_pass();
    test_or_mismatch();
    test_xor_settle1();
    test_all_fail();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Hardware exhaustive-sweep checker for combinational gates under test (generic N-input gates such as AND and OR).
- On a start pulse it drives every input combination 0..2^N_IN-1 onto the gate, waits a settle interval and samples the gate output.
- Each sample is compared against a caller-supplied truth table; the block counts mismatches and records the first failing vector.
- Sits beside gate-level lab designs as the synthesizable successor to per-gate simulation benches.

Parameters:
N_IN, 2, gate input count; legal 1..8; vectors swept = 2^N_IN.
SETTLE, 2, clock cycles each vector is held before sampling; legal 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a sweep; ignored while busy=1.
exp_tt  input  2^N_IN  expected truth table; bit k = expected gate output for input vector k; latched on an accepted start.
stim  output  N_IN  registered vector driven to the gate under test.
dut_d  input  1  gate-under-test output; sampled synchronously.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes.
pass  output  1  1 when the last completed sweep had zero mismatches; held until the next accepted start.
err_count  output  N_IN+1  mismatch count of the current/last sweep; range 0..2^N_IN, so it cannot overflow.
first_fail_idx  output  N_IN  vector index of the first mismatch.
first_fail_valid  output  1  first_fail_idx holds a valid index.

Behaviour:
- Reset (async assert, clk-synchronous deassert handled upstream):
  - state=IDLE.
  - stim, busy, done, pass, err_count, first_fail_idx and first_fail_valid all clear to 0.
  - Settle counter and latched table clear to 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1 at edge E0: latch exp_tt; stim=0; cnt=0; err_count=0; first_fail_valid=0; pass=0; busy=1; go to RUN.
- RUN, each edge:
  - If cnt != SETTLE-1: cnt++.
  - Else sample dut_d and compare it with tt[stim].
    - On mismatch: err_count++. If first_fail_valid=0, also set first_fail_idx=stim and first_fail_valid=1.
    - If stim == 2^N_IN-1: go to FIN. stim is held, not wrapped.
    - Otherwise: stim++ and cnt=0.
- Timing:
  - Vector k is sampled at edge E0 + SETTLE*(k+1).
  - The last sample is at E0 + SETTLE*2^N_IN.
- FIN (one cycle):
  - done=1.
  - pass = (err_count==0), using the count that includes the final sample.
  - busy stays 1 during FIN.
  - Next edge: done=0, busy=0, state=IDLE.
- Simultaneous events:
  - start during RUN or FIN: ignored; no restart and no re-latch.
  - start in the same cycle as the FIN→IDLE transition: ignored; it must arrive while in IDLE.
- Stability: stim changes only on sample edges, so each vector is held for exactly SETTLE cycles.
- Results persist: err_count, first_fail_* and pass keep their values in IDLE until the next accepted start.
- Reset mid-sweep: immediate abort; all outputs return to reset values; no done pulse.
- N_IN=1: two vectors. SETTLE=1: a sample every cycle.

Decomposition:
- Package gate_sweep_pkg holds:
  - the state enum (IDLE/RUN/FIN);
  - localparams NVEC = 1<<N_IN, CNT_W = clog2(SETTLE)+1, ERR_W = N_IN+1.
- One natural sub-module: settle_timer (parametrised SETTLE).
  - Inputs: clear and enable. Output: a one-cycle expire flag when the count reaches SETTLE-1.
  - The FSM, comparator and result registers stay in gate_sweep_checker.

Test Plan:
1. N_IN=2, SETTLE=2, exp_tt=4'b1000, dut_d=stim[0]&stim[1], start at E0 -> stim steps 0,1,2,3 at E0,E2,E4,E6; done pulse in the cycle after E8; pass=1; err_count=0; first_fail_valid=0.
2. Same setup, dut_d=stim[0]|stim[1] -> err_count=2; first_fail_idx=1; first_fail_valid=1; pass=0.
3. N_IN=3, SETTLE=1, exp_tt=8'h96, dut_d=^stim -> pass=1, err_count=0; busy high for exactly 9 cycles (E0..E9).
4. dut_d tied 0, exp_tt all ones, N_IN=2 -> err_count=4 (maximum, no overflow); first_fail_idx=0.
5. Pulse start again at E3 of a running sweep -> no effect; completion timing and results identical to scenario 1.
6. Assert rst_n=0 at E5 of a sweep -> outputs cleared asynchronously and no done pulse. A new start after release performs a fresh full sweep with correct results.
